store_byte_serializer: RTL

- Narrowing counterpart of the core's immediate/load extension path: takes a 32-bit store (SB/SH/SW) from the RISC-V datapath and writes it as sequential byte transactions to an 8-bit-wide data memory port.
- Sits between the execute stage's store signals and the byte-wide data RAM.
- Multi-cycle; the core stalls on `busy`.

---
 rtl/store_byte_serializer_if.sv | 35 +++
 rtl/store_byte_serializer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/store_byte_serializer_if.sv
// Store request / byte-wide memory write bundle between the core, the
// store serializer and the data RAM.
interface store_byte_serializer_if #(
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;

  // core -> serializer store request
  logic              start;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  // serializer -> core status
  logic              busy;
  logic              done;
  logic              err;
  // serializer <-> byte-wide data RAM
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [BYTE_W-1:0] mem_byte;

  // core and RAM side
  modport master (
    output start, funct3, addr, wdata, mem_ready,
    input  busy, done, err, mem_valid, mem_addr, mem_byte
  );

  // serializer side
  modport slave (
    input  start, funct3, addr, wdata, mem_ready,
    output busy, done, err, mem_valid, mem_addr, mem_byte
  );
endinterface

// File: rtl/store_byte_serializer.sv
// Splits a 32-bit RISC-V store (SB/SH/SW) into little-endian byte writes
// on an 8-bit memory port. Misaligned or illegal stores finish with err
// and issue no write.
module store_byte_serializer #(
  parameter int unsigned ADDR_W = 32
) (
  input logic                    clk,
  input logic                    reset,
  store_byte_serializer_if.slave bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned SHA_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FIN   = 2'd2
  } state_t;

  // Operands captured on the accepting edge; last holds byte count - 1.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  last;
    logic              err;
  } req_t;

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic [IDX_W-1:0]  dec_last;
  logic              dec_bad;

  logic [SHA_W-1:0]  byte_shift;
  logic [ADDR_W-1:0] next_addr;
  logic [BYTE_W-1:0] next_byte;

  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              mem_valid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [BYTE_W-1:0] mem_byte_q;

  // Decode store width and alignment of the incoming request.
  always_comb begin
    dec_last = IDX_W'(0);
    dec_bad  = 1'b0;
    case (bus.funct3)
      3'b000: dec_last = IDX_W'(0);
      3'b001: begin
        dec_last = IDX_W'(1);
        dec_bad  = bus.addr[0];
      end
      3'b010: begin
        dec_last = IDX_W'(3);
        dec_bad  = |bus.addr[1:0];
      end
      default: dec_bad = 1'b1;
    endcase
  end

  // Next-state logic: accept in IDLE, advance bytes on ready, one FIN cycle.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          req_d.addr = bus.addr;
          req_d.data = bus.wdata;
          req_d.last = dec_last;
          req_d.err  = dec_bad;
          idx_d      = IDX_W'(0);
          state_d    = dec_bad ? FIN : WRITE;
        end
      end
      WRITE: begin
        if (bus.mem_ready) begin
          if (idx_q == req_q.last) begin
            state_d = FIN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address and byte lane of the write that will be presented next cycle.
  always_comb begin
    byte_shift = {idx_d, 3'b000};
    next_addr  = req_d.addr + ADDR_W'(idx_d);
    next_byte  = BYTE_W'(req_d.data >> byte_shift);
  end

  // State, operand and registered-output update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_q       <= '0;
      idx_q       <= IDX_W'(0);
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= ADDR_W'(0);
      mem_byte_q  <= BYTE_W'(0);
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      idx_q       <= idx_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == FIN);
      err_q       <= (state_d == FIN) && req_d.err;
      mem_valid_q <= (state_d == WRITE);
      if (state_d == WRITE) begin
        mem_addr_q <= next_addr;
        mem_byte_q <= next_byte;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_byte  = mem_byte_q;

endmodule
